// File: rtl/fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_if
//   Instruction-memory fetch bus between the fetch sequencer and the
//   instruction memory. The fetch side raises mem_req with a stable mem_addr.
//   The memory answers with mem_ack and mem_rdata, which may arrive in the
//   same cycle as the request.
//
//   Signals
//     mem_req    fetch request            (master -> slave)
//     mem_addr   fetch address, W bits    (master -> slave)
//     mem_ack    read data valid          (slave  -> master)
//     mem_rdata  instruction word, W bits (slave  -> master)
// ----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int W = 16
);
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer that sits between the program counter, the
//   instruction memory and decode. It fetches the word at pc_in and holds it
//   in ir until decode consumes it or takes a relative branch. It also drives
//   the pc's one-hot inc/add/sub pulses.
//
//   Parameters
//     W        datapath width; must equal the pc width
//     TIMEOUT  REQ cycles without mem_ack before fetch_err (0 = never)
//
//   Ports
//     clk, reset          clock; asynchronous active-high reset
//     run                 1 = fetch continuously, 0 = stop after current ir
//     pc_in               current pc value
//     pc_inc/add/sub      one-cycle pc update pulses (at most one high)
//     pc_offset           branch magnitude while pc_add/pc_sub, else 0
//     mem                 fetch bus (fetch_ctrl_if.master)
//     ir, ir_valid        instruction register and its valid flag
//     ir_ready            decode consumes ir when ir_valid & ir_ready
//     br_valid, br_offset relative branch request, signed offset
//     br_ready            branch accepted this cycle (state HOLD)
//     fetch_err           sticky memory-timeout flag
//     fetch_cnt/stall_cnt saturating performance counters
//
//   Build option
//     FETCH_CTRL_PERF_EN  when defined, fetch_cnt counts accepted fetches and
//                         stall_cnt counts REQ cycles without mem_ack.
//                         Otherwise both read constant 0.
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int W       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic [W-1:0] pc_in,
    output logic         pc_inc,
    output logic         pc_add,
    output logic         pc_sub,
    output logic [W-1:0] pc_offset,
    fetch_ctrl_if.master mem,
    output logic [W-1:0] ir,
    output logic         ir_valid,
    input  logic         ir_ready,
    input  logic         br_valid,
    input  logic [W-1:0] br_offset,
    output logic         br_ready,
    output logic         fetch_err,
    output logic [W-1:0] fetch_cnt,
    output logic [W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ERR
    } state_t;

    localparam bit               TO_EN    = (TIMEOUT > 0);
    localparam int               CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0]      TO_LIMIT = (CW + 1)'(TIMEOUT);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait;
    logic [CW:0]   w_wait_inc;
    logic          w_timeout;
    logic          w_ack;

    // The wait count is one bit wider so the compare against TIMEOUT cannot wrap.
    assign w_wait_inc = {1'b0, r_wait} + {{CW{1'b0}}, 1'b1};
    assign w_timeout  = TO_EN && (w_wait_inc == TO_LIMIT);
    assign w_ack      = (r_state == S_REQ) && mem.mem_ack;

    // ERR is left only by reset, so the state itself is the sticky flag.
    assign fetch_err  = (r_state == S_ERR);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, whatever order the simulator evaluates the blocks in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default before the case
    // statement, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next       = r_state;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        pc_inc       = 1'b0;
        pc_add       = 1'b0;
        pc_sub       = 1'b0;
        pc_offset    = '0;
        ir_valid     = 1'b0;
        br_ready     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_REQ;
                end
            end

            // run is ignored here on purpose: a started fetch always completes.
            S_REQ: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_in;
                if (mem.mem_ack) begin
                    pc_inc = 1'b1;
                    w_next = S_HOLD;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end

            // A branch wins over ir_ready. pc_add/pc_sub take a magnitude, so a
            // negative offset is negated; 0x8000 negates to itself, which is the
            // correct magnitude for the most negative offset.
            S_HOLD: begin
                ir_valid = 1'b1;
                br_ready = 1'b1;
                if (br_valid) begin
                    if (!br_offset[W-1]) begin
                        pc_add    = 1'b1;
                        pc_offset = br_offset;
                    end else begin
                        pc_sub    = 1'b1;
                        pc_offset = -br_offset;
                    end
                    w_next = run ? S_REQ : S_IDLE;
                end else if (ir_ready) begin
                    w_next = run ? S_REQ : S_IDLE;
                end
            end

            S_ERR: begin
                w_next = S_ERR;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // NOTE: ir is a plain datapath register, but it is reset anyway because
    // decode can observe it and reset must read back as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (w_ack) begin
            ir <= mem.mem_rdata;
        end
    end

    // The wait counter runs only during unacknowledged REQ cycles and is 0 in
    // every other state, so each new request starts counting from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if ((r_state == S_REQ) && !mem.mem_ack) begin
            r_wait <= w_wait_inc[CW-1:0];
        end else begin
            r_wait <= '0;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_fetch_cnt;
    logic [W-1:0] r_stall_cnt;

    // Both counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == S_REQ) begin
            if (mem.mem_ack) begin
                if (~&r_fetch_cnt) begin
                    r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
                end
            end else if (~&r_stall_cnt) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
